// File: rtl/mbist_addr_gen_if.sv
// rtl/mbist_addr_gen_if.sv - MBIST control FSM <-> address generator signal bundle
interface mbist_addr_gen_if #(
  parameter int BIST_ADDR_WD = 9
);
  logic                    bist_run;
  logic                    run_op;
  logic                    run_addr;
  logic                    run_sti;
  logic                    last_op;
  logic                    op_reverse;
  logic                    sti_addr_down;
  logic                    cmp_phase;
  logic                    bist_error;
  logic [BIST_ADDR_WD-1:0] bist_addr;
  logic                    last_addr;
  logic                    addr_dir;
  logic [BIST_ADDR_WD-1:0] error_addr;
  logic                    error_valid;

  modport master (
    output bist_run, run_op, run_addr, run_sti, last_op, op_reverse,
           sti_addr_down, cmp_phase, bist_error,
    input  bist_addr, last_addr, addr_dir, error_addr, error_valid
  );

  modport slave (
    input  bist_run, run_op, run_addr, run_sti, last_op, op_reverse,
           sti_addr_down, cmp_phase, bist_error,
    output bist_addr, last_addr, addr_dir, error_addr, error_valid
  );
endinterface

// File: rtl/mbist_addr_gen.sv
// rtl/mbist_addr_gen.sv - MBIST address generator with reversal and first-fail capture
// Optional Gray-coded physical address when MBIST_ADDR_SCRAMBLE_EN is defined.
module mbist_addr_gen #(
  parameter int          BIST_ADDR_WD    = 9,
  parameter int unsigned BIST_ADDR_START = 0,
  parameter int unsigned BIST_ADDR_END   = (1 << BIST_ADDR_WD) - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mbist_addr_gen_if.slave      bus
);

  localparam logic [BIST_ADDR_WD-1:0] L_START = BIST_ADDR_WD'(BIST_ADDR_START);
  localparam logic [BIST_ADDR_WD-1:0] L_END   = BIST_ADDR_WD'(BIST_ADDR_END);
  localparam logic [BIST_ADDR_WD-1:0] L_ONE   = BIST_ADDR_WD'(1);
  localparam logic                    L_LAST_RST = (L_START == L_END);

  logic [BIST_ADDR_WD-1:0] r_laddr;
  logic                    r_dir;
  logic                    r_last_addr;
  logic [BIST_ADDR_WD-1:0] r_err_addr;
  logic                    r_err_v;
  logic                    r_bist_run_d;

  logic [BIST_ADDR_WD-1:0] w_laddr_next;
  logic                    w_dir_next;
  logic                    w_last_next;
  logic [BIST_ADDR_WD-1:0] w_bist_addr;
  logic                    w_run_rise;
  logic                    w_err_v_eff;
  logic                    w_capture;

  always_comb begin
    w_laddr_next = r_laddr;
    w_dir_next   = r_dir;
    if (!bus.bist_run || bus.run_sti) begin
      w_dir_next   = bus.sti_addr_down;
      w_laddr_next = bus.sti_addr_down ? L_END : L_START;
    end else if (bus.run_op && bus.last_op && bus.op_reverse && r_last_addr) begin
      // terminal address is kept and becomes the first address of the reversed sweep
      w_dir_next = ~r_dir;
    end else if (bus.run_addr) begin
      if (r_last_addr)
        w_laddr_next = r_dir ? L_END : L_START;
      else
        w_laddr_next = r_dir ? (r_laddr - L_ONE) : (r_laddr + L_ONE);
    end
    w_last_next = (w_laddr_next == (w_dir_next ? L_START : L_END));
  end

`ifdef MBIST_ADDR_SCRAMBLE_EN
  assign w_bist_addr = r_laddr ^ (r_laddr >> 1);
`else
  assign w_bist_addr = r_laddr;
`endif

  // a new run discards the previous capture, but an error on that very cycle still counts
  assign w_run_rise  = bus.bist_run && !r_bist_run_d;
  assign w_err_v_eff = r_err_v && !w_run_rise;
  assign w_capture   = bus.bist_run && bus.cmp_phase && bus.bist_error && !w_err_v_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_laddr      <= L_START;
      r_dir        <= 1'b0;
      r_last_addr  <= L_LAST_RST;
      r_err_addr   <= '0;
      r_err_v      <= 1'b0;
      r_bist_run_d <= 1'b0;
    end else begin
      r_laddr      <= w_laddr_next;
      r_dir        <= w_dir_next;
      r_last_addr  <= w_last_next;
      r_bist_run_d <= bus.bist_run;
      if (w_capture) begin
        r_err_addr <= w_bist_addr;
        r_err_v    <= 1'b1;
      end else if (w_run_rise) begin
        r_err_v    <= 1'b0;
      end
    end
  end

  assign bus.bist_addr   = w_bist_addr;
  assign bus.last_addr   = r_last_addr;
  assign bus.addr_dir    = r_dir;
  assign bus.error_addr  = r_err_addr;
  assign bus.error_valid = r_err_v;

endmodule
